// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of WIDTH JK flip-flops.
// Turns clear/load/count-up/toggle commands into legal per-bit J/K drive using live Q feedback.
module jk_bank_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             Cp,
   input  logic             R,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [3:0]       cmd_len,
   input  logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_CLEAR  = 2'b00;
   localparam logic [1:0] OP_LOAD   = 2'b01;
   localparam logic [1:0] OP_COUNT  = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   state_t             state_r;
   state_t             state_s;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   data_r;
   logic [4:0]         rem_r;
   logic               accept_s;
   logic               last_step_s;
   logic [WIDTH-1:0]   carry_s;

   assign accept_s    = cmd_valid && (state_r == IDLE) && !R;
   // A zero-length count still spends one EXEC cycle, so rem_r == 0 also ends the command.
   assign last_step_s = (op_r != OP_COUNT) || (rem_r <= 5'd1);

   // FSM state register.
   always_ff @(posedge Cp or posedge R) begin
      if (R) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Latched command fields and remaining count steps.
   always_ff @(posedge Cp or posedge R) begin
      if (R) begin
         op_r   <= 2'b00;
         data_r <= '0;
         rem_r  <= 5'd0;
      end else if (accept_s) begin
         op_r   <= cmd_op;
         data_r <= cmd_data;
         rem_r  <= {1'b0, cmd_len};
      end else if ((state_r == EXEC) && (rem_r != 5'd0)) begin
         rem_r  <= rem_r - 5'd1;
      end else begin
         rem_r  <= rem_r;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = EXEC;
            end else begin
               state_s = IDLE;
            end
         end
         EXEC: begin
            if (last_step_s) begin
               state_s = DONE;
            end else begin
               state_s = EXEC;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Ripple-carry enables for a synchronous binary increment of the bank.
   always_comb begin
      carry_s    = '0;
      carry_s[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         carry_s[i] = carry_s[i-1] & Q[i-1];
      end
   end

   // Output decode: handshake/status from state, J/K from latched op and live Q.
   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      J         = '0;
      K         = '0;
      case (state_r)
         IDLE: begin
            if (R) begin
               cmd_ready = 1'b0;
            end else begin
               cmd_ready = 1'b1;
            end
         end
         EXEC: begin
            busy = 1'b1;
            case (op_r)
               OP_CLEAR: begin
                  J = '0;
                  K = '1;
               end
               OP_LOAD: begin
                  J = data_r;
                  K = ~data_r;
               end
               OP_COUNT: begin
                  if (rem_r != 5'd0) begin
                     J = carry_s;
                     K = carry_s;
                  end else begin
                     J = '0;
                     K = '0;
                  end
               end
               OP_TOGGLE: begin
                  J = data_r;
                  K = data_r;
               end
               default: begin
                  J = '0;
                  K = '0;
               end
            endcase
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            cmd_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer driving a modelled 4-bit JK flip-flop bank.
// Final bank values are queued per command and compared when done pulses.
module tb_jk_bank_sequencer;

   logic       Cp;
   logic       R;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_data;
   logic [3:0] cmd_len;
   logic [3:0] q_bank;
   logic [3:0] J;
   logic [3:0] K;
   logic       busy;
   logic       done;

   int         total;
   int         bad;
   logic [3:0] exp_q[$];

   jk_bank_sequencer #(.WIDTH(4)) dut (
      .Cp(Cp), .R(R), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
      .Q(q_bank), .J(J), .K(K), .busy(busy), .done(done)
   );

   initial begin
      Cp = 1'b0;
      forever #5 Cp = ~Cp;
   end

   // Bank of four JK flip-flops sharing clock and reset with the sequencer.
   always_ff @(posedge Cp or posedge R) begin
      if (R) begin
         q_bank <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            case ({J[i], K[i]})
               2'b00:   q_bank[i] <= q_bank[i];
               2'b01:   q_bank[i] <= 1'b0;
               2'b10:   q_bank[i] <= 1'b1;
               default: q_bank[i] <= ~q_bank[i];
            endcase
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Called at a negedge while idle; returns just after the accepting posedge.
   task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [3:0] len,
                        input logic [3:0] final_q, input bit hold_junk);
      check("ready_at_issue", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_len   = len;
      exp_q.push_back(final_q);
      @(posedge Cp);
      #1;
      if (hold_junk) begin
         cmd_op   = 2'b01;
         cmd_data = 4'b1111;
         cmd_len  = 4'd9;
      end else begin
         cmd_valid = 1'b0;
      end
   endtask

   // Waits for done within a cycle budget; checks latency, per-step Q of counts, and final Q.
   task automatic await_done(input int steps, input logic [3:0] start, input bit is_cnt);
      int         n;
      bit         seen;
      logic [3:0] want;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge Cp);
         n++;
         if (done) begin
            seen = 1'b1;
         end else begin
            check("busy_exec", 32'(busy), 32'd1);
            check("ready_exec", 32'(cmd_ready), 32'd0);
            if (is_cnt) check("count_step_q", 32'(q_bank), 32'(4'(start + n - 1)));
         end
      end
      check("done_seen", 32'(seen), 32'd1);
      check("done_latency", 32'(n), 32'(steps + 1));
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         check("final_q", 32'(q_bank), 32'(want));
      end else begin
         check("scoreboard_nonempty", 32'd0, 32'd1);
      end
      check("done_j", 32'(J), 32'd0);
      check("done_k", 32'(K), 32'd0);
      check("done_busy", 32'(busy), 32'd1);
      check("done_ready", 32'(cmd_ready), 32'd0);
   endtask

   task automatic post_done();
      @(negedge Cp);
      check("idle_done_low", 32'(done), 32'd0);
      check("idle_ready", 32'(cmd_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_j", 32'(J), 32'd0);
      check("idle_k", 32'(K), 32'd0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      R         = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = 4'b0000;
      cmd_len   = 4'd0;

      @(negedge Cp);
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_j", 32'(J), 32'd0);
      check("rst_k", 32'(K), 32'd0);
      @(negedge Cp);
      R = 1'b0;
      @(negedge Cp);

      issue(2'b01, 4'b1011, 4'd0, 4'b1011, 1'b0);
      await_done(1, 4'b0000, 1'b0);
      post_done();

      issue(2'b10, 4'b0000, 4'd7, 4'b0010, 1'b0);
      await_done(7, 4'b1011, 1'b1);
      post_done();

      issue(2'b11, 4'b0110, 4'd0, 4'b0100, 1'b0);
      await_done(1, 4'b0000, 1'b0);
      post_done();

      issue(2'b00, 4'b1111, 4'd0, 4'b0000, 1'b0);
      await_done(1, 4'b0000, 1'b0);
      post_done();

      issue(2'b01, 4'b0101, 4'd0, 4'b0101, 1'b0);
      await_done(1, 4'b0000, 1'b0);
      post_done();
      issue(2'b10, 4'b1010, 4'd0, 4'b0101, 1'b0);
      await_done(1, 4'b0000, 1'b0);
      post_done();

      issue(2'b01, 4'b1111, 4'd0, 4'b1111, 1'b0);
      await_done(1, 4'b0000, 1'b0);
      post_done();
      issue(2'b10, 4'b0000, 4'd1, 4'b0000, 1'b0);
      await_done(1, 4'b1111, 1'b1);
      post_done();

      // Junk command held valid through EXEC/DONE, real command presented in DONE.
      issue(2'b01, 4'b0011, 4'd0, 4'b0011, 1'b1);
      await_done(1, 4'b0000, 1'b0);
      cmd_op   = 2'b11;
      cmd_data = 4'b1111;
      cmd_len  = 4'd0;
      exp_q.push_back(4'b1100);
      @(negedge Cp);
      check("hs_idle_ready", 32'(cmd_ready), 32'd1);
      check("hs_idle_q", 32'(q_bank), 32'(4'b0011));
      @(posedge Cp);
      #1;
      cmd_valid = 1'b0;
      await_done(1, 4'b0000, 1'b0);
      post_done();

      // Reset during EXEC step 3 of a len=10 count.
      issue(2'b10, 4'b0000, 4'd10, 4'b0110, 1'b0);
      repeat (3) @(negedge Cp);
      check("mid_q_step3", 32'(q_bank), 32'(4'b1110));
      check("mid_j_step3", 32'(J), 32'(4'b0001));
      R = 1'b1;
      #1;
      check("abort_j", 32'(J), 32'd0);
      check("abort_k", 32'(K), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd0);
      check("abort_q", 32'(q_bank), 32'd0);
      void'(exp_q.pop_back());
      repeat (2) begin
         @(negedge Cp);
         check("abort_no_done", 32'(done), 32'd0);
      end
      R = 1'b0;
      #1;
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
      @(negedge Cp);
      check("post_rst_no_done", 32'(done), 32'd0);
      check("post_rst_q", 32'(q_bank), 32'd0);

      issue(2'b10, 4'b0000, 4'd15, 4'b1111, 1'b0);
      await_done(15, 4'b0000, 1'b1);
      post_done();

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Command-driven controller for a bank of WIDTH JK flip-flops sharing one clock and reset. It accepts clear, load, count-up and toggle commands over a valid/ready handshake. Each cycle it computes per-bit J/K drive from the latched command and the bank's Q feedback. It sits between a requester and the JK-FF bank, so the bank is only ever driven through legal J/K combinations.

## Interface
Parameters:
- WIDTH, 4, number of JK flip-flops in the controlled bank (2..16)

Ports:
- Cp  input  1  clock; all state updates on rising edge; the bank shares this clock
- R  input  1  reset, asynchronous, active-high; the bank shares this reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00 clear, 01 load, 10 count-up, 11 toggle-mask
- cmd_data  input  WIDTH  load value (load) or toggle mask (toggle); ignored otherwise
- cmd_len  input  4  number of count steps (count-up only); ignored otherwise
- Q  input  WIDTH  feedback from bank outputs
- J  output  WIDTH  J drive to bank, bit i to FF i
- K  output  WIDTH  K drive to bank, bit i to FF i
- busy  output  1  high in EXEC and DONE
- done  output  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, EXEC, DONE. Registers: state, op, data, remaining step count (5 bits).
- IDLE: cmd_ready=1, J=K=0 (bank holds). A command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1. The controller latches op/data/len and goes to EXEC. cmd_valid while not ready is ignored; the command is not queued.
- EXEC drive (combinational from latched op/data and live Q):
  - clear: J=0, K=all ones. 1 cycle.
  - load: J=data, K=~data. 1 cycle.
  - toggle: J=K=data. 1 cycle.
  - count-up: J[0]=K[0]=1; J[i]=K[i]=&Q[i-1:0]. This is a synchronous binary increment. Runs len cycles; the counter decrements each edge.
  - count-up with len=0: 1 EXEC cycle with J=K=0. The bank is unchanged and done still pulses.
- EXEC→DONE on the edge that applies the last step. DONE: J=K=0, done=1, busy=1, cmd_ready=0. DONE→IDLE on the next edge.
- Arithmetic: after a count of L, Q = (Q_start + L) mod 2^WIDTH. Wrap from all-ones to zero is natural and not flagged.
- Q is sampled only combinationally during EXEC. Changes to Q from other sources are not detected.
- Reset (R=1, any time, including mid-EXEC): state=IDLE immediately. Outputs go to J=0, K=0, cmd_ready=0, busy=0, done=0. Latched fields are cleared and the in-flight command is aborted with no done pulse. cmd_ready rises in the first cycle after R deasserts.

## Timing
- Edge e0: accept. EXEC occupies the cycles before edges e1..eL, where L=1 for clear/load/toggle/len=0 and L=len otherwise. The bank updates at each of e1..eL.
- DONE is the cycle after eL, with done high for exactly one cycle. IDLE and cmd_ready=1 follow from edge eL+1.
- Minimum accept-to-accept spacing is L+2 cycles, i.e. 3 for single-step ops and 17 for len=15.
- J/K are stable from shortly after each edge until the next edge. Q feedback is combinational into J/K in EXEC, with no cycle of lag.
- done and the final bank value coincide: in the DONE cycle Q already holds the result.

## Test plan
Bench: WIDTH=4, with a bank of four of the team's JK_FF cells sharing Cp and R with the DUT.
- Reset then load: R pulse; load cmd_data=4'b1011 → cmd_ready=0 for 2 cycles, Q=1011 in DONE, done high for 1 cycle, cmd_ready=1 the cycle after.
- Count: from Q=1011, count-up len=7 → Q steps 1100,1101,1110,1111,0000,0001,0010 on e1..e7; done in the cycle after e7; busy high for 8 cycles.
- Toggle and clear: from 0010, toggle mask 0110 → Q=0100; then clear → Q=0000; J=K=0 in IDLE and DONE throughout.
- Boundary: count-up len=0 from Q=0101 → Q stays 0101, done pulses 2 cycles after accept. Count-up len=1 from Q=1111 → Q=0000.
- Handshake: cmd_valid held high with different data during EXEC and DONE → the ignored commands have no effect; the next command is accepted only on the edge where cmd_ready=1.
- Reset mid-operation: assert R asynchronously mid-cycle during EXEC step 3 of a len=10 count → J=K=0, busy=0 and Q=0000 immediately (bank reset), no done pulse, cmd_ready=1 the cycle after R falls.
